// File: rtl/fma_addend_align.sv
// ---------------------------------------------------------------------------
// fma_addend_align
//   Iterative alignment shifter for the FMA addend. Takes the exponent
//   difference d = ea+eb-ec and places mant_c at the top of an AW-bit field,
//   then shifts it right by s = d+MW+2 (clamped to 0..AW). The shift runs at
//   up to STEP bits per cycle. Every bit that falls off the bottom is ORed
//   into sticky. When the product is negligible (ab_req=0), the field is
//   returned unshifted and bypass is set.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready request handshake; in_ready is high only in IDLE
//   mant_c [MW-1:0]   addend mantissa, MSB = hidden bit
//   shamt  [7:0]      two's-complement exponent difference d
//   ab_req            1 = align, 0 = bypass
//   out_valid/out_ready  result handshake; the result is held while stalled
//   aligned_c [AW-1:0] aligned addend field
//   sticky            OR of all addend bits shifted below bit 0
//   bypass            result came from the ab_req=0 path
// ---------------------------------------------------------------------------
module fma_addend_align #(
  parameter int MW   = 24,
  parameter int STEP = 8,
  localparam int AW  = 3*MW+2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW-1:0] mant_c,
  input  logic [7:0]    shamt,
  input  logic          ab_req,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] aligned_c,
  output logic          sticky,
  output logic          bypass
);

  localparam int RW = $clog2(AW+1);
  localparam logic signed [9:0] AW_S  = 10'(AW);
  localparam logic signed [9:0] OFF_S = 10'(MW+2);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e          state_q;
  logic [AW-1:0]   field_q;
  logic            sticky_q;
  logic            bypass_q;
  logic [RW-1:0]   rem_q;

  // Total right shift, computed signed so that negative d is visible.
  logic signed [9:0] s_raw;
  logic [RW-1:0]     s_clamp;
  logic [RW-1:0]     step_k;
  logic [AW-1:0]     drop_mask;
  logic [AW-1:0]     field_init;

  assign s_raw      = $signed({{2{shamt[7]}}, shamt}) + OFF_S;
  assign field_init = {mant_c, {(AW-MW){1'b0}}};

  always_comb begin
    s_clamp = '0;
    if (s_raw < 0)          s_clamp = '0;
    else if (s_raw > AW_S)  s_clamp = RW'(AW);
    else                    s_clamp = s_raw[RW-1:0];
  end

  // Distance for this cycle and the bits it pushes out of the field.
  assign step_k    = (rem_q < RW'(STEP)) ? rem_q : RW'(STEP);
  assign drop_mask = ~({AW{1'b1}} << step_k);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      field_q  <= '0;
      sticky_q <= 1'b0;
      bypass_q <= 1'b0;
      rem_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            field_q  <= field_init;
            sticky_q <= 1'b0;
            if (!ab_req) begin
              bypass_q <= 1'b1;
              rem_q    <= '0;
              state_q  <= DONE;
            end else begin
              bypass_q <= 1'b0;
              rem_q    <= s_clamp;
              state_q  <= (s_clamp == '0) ? DONE : SHIFT;
            end
          end
        end
        SHIFT: begin
          field_q  <= field_q >> step_k;
          sticky_q <= sticky_q | (|(field_q & drop_mask));
          rem_q    <= rem_q - step_k;
          if (rem_q == step_k) state_q <= DONE;
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign aligned_c = field_q;
  assign sticky    = sticky_q;
  assign bypass    = bypass_q;

endmodule
